keypad_scan_debounce: RTL and testbench

Scans a 4x4 matrix keypad by driving columns one at a time and sampling the rows. It synchronizes and debounces the row inputs. Each debounced press produces exactly one single-cycle key_valid pulse with a 4-bit hex key code. It sits directly upstream of the hex digit shift stage, which consumes key_valid/key_code, and runs on the divided system clock.

---
 rtl/keypad_scan_debounce.sv | 150 +++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: drives one column low at a time, synchronizes and
// debounces the rows, and emits one key_valid pulse with a hex code per press.
module keypad_scan_debounce #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code
);
    localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       row_meta_q, row_s_q;
    logic [3:0]       col_q, col_d;
    logic [1:0]       c_q, c_d;
    logic [1:0]       r_q, r_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;

    logic             one_low;
    logic [1:0]       low_idx;
    logic             only_r_low;
    logic             advance;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    // Exactly one row low is the only pattern treated as a valid single key.
    always_comb begin
        one_low = 1'b0;
        low_idx = 2'd0;
        case (row_s_q)
            4'b1110: begin one_low = 1'b1; low_idx = 2'd0; end
            4'b1101: begin one_low = 1'b1; low_idx = 2'd1; end
            4'b1011: begin one_low = 1'b1; low_idx = 2'd2; end
            4'b0111: begin one_low = 1'b1; low_idx = 2'd3; end
            default: ;
        endcase
    end

    assign only_r_low = (row_s_q == ~(4'b0001 << r_q));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        c_d         = c_q;
        r_d         = r_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        advance     = 1'b0;
        case (state_q)
            SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (one_low) begin
                        r_d     = low_idx;
                        state_d = DEBOUNCE;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DEBOUNCE: begin
                if (!only_r_low) begin
                    cnt_d   = '0;
                    state_d = SCAN;
                    advance = 1'b1;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d       = '0;
                    state_d     = HELD;
                    key_valid_d = 1'b1;
                    key_code_d  = key_map(r_q, c_q);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (row_s_q[r_q]) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            default: begin
                if (!row_s_q[r_q]) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = SCAN;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
        // Column drive is a rotating one-hot-low register, so it can never glitch.
        if (advance) begin
            col_d = {col_q[2:0], col_q[3]};
            c_d   = c_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_q  <= 4'b1111;
            row_s_q     <= 4'b1111;
            state_q     <= SCAN;
            cnt_q       <= '0;
            col_q       <= 4'b1110;
            c_q         <= 2'd0;
            r_q         <= 2'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            row_meta_q  <= row;
            row_s_q     <= row_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            c_q         <= c_d;
            r_q         <= r_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign col       = col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a keypad model and a code scoreboard.
module tb_keypad_scan_debounce;
    localparam int SETTLE = 4;
    localparam int DEB    = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;

    logic [15:0] pressed = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  prev_code = 4'h0;
    logic        prev_valid = 1'b0;
    logic [3:0]  exp_col;
    logic [3:0]  exp_code;
    logic        saw_col2;

    keypad_scan_debounce #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .key_valid(key_valid), .key_code(key_code)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: legal column drive, no back-to-back pulses, code stable between pulses,
    // and every pulse matched against the next expected code.
    always @(negedge clk) begin
        if (!reset) begin
            prev_code  = 4'h0;
            prev_valid = 1'b0;
        end else begin
            chk("col_onehot_low", 8'($countones(~col)), 8'd1);
            if (key_valid) begin
                chk("pulse_not_consecutive", 8'(prev_valid), 8'd0);
                chk("pulse_expected", 8'(exp_q.size() != 0), 8'd1);
                if (exp_q.size() != 0) begin
                    exp_code = exp_q.pop_front();
                    chk("pulse_code", 8'(key_code), 8'(exp_code));
                end
            end else begin
                chk("code_stable", 8'(key_code), 8'(prev_code));
            end
            prev_code  = key_code;
            prev_valid = key_valid;
        end
    end

    initial begin
        // Reset values
        step(2);
        chk("rst_col", 8'(col), 8'h0E);
        chk("rst_valid", 8'(key_valid), 8'h0);
        chk("rst_code", 8'(key_code), 8'h0);
        reset = 1'b1;

        // Idle scan: each column held SETTLE cycles, rotating 1110,1101,1011,0111
        for (int k = 0; k < 20; k++) begin
            exp_col = ~(4'b0001 << ((k / SETTLE) % 4));
            chk("idle_col", 8'(col), 8'(exp_col));
            step(1);
        end

        // Clean press of '5', held 100 cycles, then released
        pressed[1*4+1] = 1'b1;
        exp_q.push_back(4'h5);
        step(100);
        chk("held5_col", 8'(col), 8'h0D);
        chk("held5_code", 8'(key_code), 8'h5);
        chk("held5_sb_empty", 8'(exp_q.size()), 8'd0);
        pressed[1*4+1] = 1'b0;
        step(2 + 1 + DEB - 1);
        chk("rel5_col_hold", 8'(col), 8'h0D);
        step(1);
        chk("rel5_col_adv", 8'(col), 8'h0B);
        step(10);

        // Bouncy press of 'D' then bouncy release
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) pressed[3*4+3] = ~pressed[3*4+3];
            step(1);
        end
        pressed[3*4+3] = 1'b1;
        exp_q.push_back(4'hD);
        step(40);
        chk("heldD_col", 8'(col), 8'h07);
        chk("heldD_code", 8'(key_code), 8'hD);
        chk("heldD_sb_empty", 8'(exp_q.size()), 8'd0);
        for (int i = 0; i < 4; i++) begin
            pressed[3*4+3] = ~pressed[3*4+3];
            step(2);
        end
        pressed[3*4+3] = 1'b0;
        step(30);

        // Hold '1', add '9' meanwhile: only '1' reported; then '9' alone
        pressed[0*4+0] = 1'b1;
        exp_q.push_back(4'h1);
        step(40);
        pressed[2*4+2] = 1'b1;
        step(30);
        chk("hold1_col", 8'(col), 8'h0E);
        chk("hold1_code", 8'(key_code), 8'h1);
        pressed[2*4+2] = 1'b0;
        step(5);
        pressed[0*4+0] = 1'b0;
        step(20);
        chk("hold1_sb_empty", 8'(exp_q.size()), 8'd0);
        pressed[2*4+2] = 1'b1;
        exp_q.push_back(4'h9);
        step(40);
        chk("press9_code", 8'(key_code), 8'h9);
        chk("press9_sb_empty", 8'(exp_q.size()), 8'd0);
        pressed[2*4+2] = 1'b0;
        step(20);

        // '3' and '6' together in one column: no pulse, scanning continues
        pressed[0*4+2] = 1'b1;
        pressed[1*4+2] = 1'b1;
        saw_col2 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (col == 4'b1011) saw_col2 = 1'b1;
        end
        chk("dual_scanning", 8'(saw_col2), 8'd1);
        chk("dual_code_kept", 8'(key_code), 8'h9);
        pressed[1*4+2] = 1'b0;
        exp_q.push_back(4'h3);
        step(40);
        chk("press3_code", 8'(key_code), 8'h3);
        chk("press3_sb_empty", 8'(exp_q.size()), 8'd0);
        pressed[0*4+2] = 1'b0;
        step(20);

        // Reset during HELD, key kept pressed through reset
        pressed[1*4+1] = 1'b1;
        exp_q.push_back(4'h5);
        step(40);
        chk("pre_rst_sb_empty", 8'(exp_q.size()), 8'd0);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_col", 8'(col), 8'h0E);
        chk("async_rst_valid", 8'(key_valid), 8'h0);
        chk("async_rst_code", 8'(key_code), 8'h0);
        step(3);
        exp_q.push_back(4'h5);
        reset = 1'b1;
        // Column 1 is sampled in cycle 2*SETTLE-1; the pulse follows DEB+1 cycles later
        for (int k = 0; k < 2 * SETTLE - 1 + DEB + 1; k++) begin
            chk("rst_relatch_wait", 8'(key_valid), 8'h0);
            step(1);
        end
        chk("rst_relatch_pulse", 8'(key_valid), 8'h1);
        chk("rst_relatch_code", 8'(key_code), 8'h5);
        pressed[1*4+1] = 1'b0;
        step(30);
        chk("final_sb_empty", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
